axi4_lite_master: RTL

Command-to-AXI4-Lite bridge that sits directly upstream of the team's AXI4-Lite slave register block and drives its five channels. It accepts one read or write command at a time on a simple valid/ready command port. It runs the full AXI4-Lite handshake sequence, then returns read data and response code on a valid/ready response port. Only one transaction is outstanding at a time, and it keeps counts of completed reads and writes.

---
 rtl/axi4_lite_master.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Brief    : Single-outstanding command-to-AXI4-Lite bridge with completion
//            counters and a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    // write address channel
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    // write response channel
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY,
    // completion counters
    output logic [CNT_WIDTH-1:0]      wr_count,
    output logic [CNT_WIDTH-1:0]      rd_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wr_req  = 3'd1;
    localparam logic [2:0] c_st_wr_resp = 3'd2;
    localparam logic [2:0] c_st_rd_req  = 3'd3;
    localparam logic [2:0] c_st_rd_data = 3'd4;
    localparam logic [2:0] c_st_rsp     = 3'd5;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;

    logic                     r_aw_done;
    logic                     r_w_done;

    logic [ADDR_WIDTH-1:0]    r_awaddr;
    logic                     r_awvalid;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_wstrb;
    logic                     r_wvalid;
    logic                     r_bready;
    logic [ADDR_WIDTH-1:0]    r_araddr;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_rsp_valid;
    logic                     r_rsp_write;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic [1:0]               r_rsp_resp;
    logic [CNT_WIDTH-1:0]     r_wr_count;
    logic [CNT_WIDTH-1:0]     r_rd_count;

    logic                     w_cmd_fire;
    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_b_hs;
    logic                     w_ar_hs;
    logic                     w_r_hs;
    logic                     w_rsp_hs;
    logic                     w_aw_fin;
    logic                     w_w_fin;

    assign cmd_ready  = (r_state == c_st_idle);

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_aw_hs    = r_awvalid & AWREADY;
    assign w_w_hs     = r_wvalid & WREADY;
    assign w_b_hs     = BVALID & r_bready;
    assign w_ar_hs    = r_arvalid & ARREADY;
    assign w_r_hs     = RVALID & r_rready;
    assign w_rsp_hs   = r_rsp_valid & rsp_ready;

    // A channel counts as finished if it completed earlier or completes now.
    assign w_aw_fin   = r_aw_done | w_aw_hs;
    assign w_w_fin    = r_w_done | w_w_hs;

    assign AWADDR     = r_awaddr;
    assign AWVALID    = r_awvalid;
    assign WDATA      = r_wdata;
    assign WSTRB      = r_wstrb;
    assign WVALID     = r_wvalid;
    assign BREADY     = r_bready;
    assign ARADDR     = r_araddr;
    assign ARVALID    = r_arvalid;
    assign RREADY     = r_rready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_write  = r_rsp_write;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_resp   = r_rsp_resp;
    assign wr_count   = r_wr_count;
    assign rd_count   = r_rd_count;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_cmd_fire) begin
                    w_state_nxt = cmd_write ? c_st_wr_req : c_st_rd_req;
                end
            end
            c_st_wr_req: begin
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt = c_st_wr_resp;
                end
            end
            c_st_wr_resp: begin
                if (w_b_hs) begin
                    w_state_nxt = c_st_rsp;
                end
            end
            c_st_rd_req: begin
                if (w_ar_hs) begin
                    w_state_nxt = c_st_rd_data;
                end
            end
            c_st_rd_data: begin
                if (w_r_hs) begin
                    w_state_nxt = c_st_rsp;
                end
            end
            c_st_rsp: begin
                if (w_rsp_hs) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_cmd_fire) begin
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= '1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                c_st_wr_req: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                    end
                end
                c_st_wr_resp: begin
                    if (w_b_hs) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= BRESP;
                        r_wr_count  <= r_wr_count + c_cnt_one;
                    end
                end
                c_st_rd_req: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                c_st_rd_data: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= RDATA;
                        r_rsp_resp  <= RRESP;
                        r_rd_count  <= r_rd_count + c_cnt_one;
                    end
                end
                c_st_rsp: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
